// File: rtl/dac_sample_sequencer.sv
// rtl/dac_sample_sequencer.sv - debounced waveform select, sample-rate divider and DAC code sequencer
module dac_sample_sequencer #(
    parameter int                SAMPLE_DIV = 100,
    parameter int                DATA_W     = 8,
    parameter int                DEB_CYCLES = 100000,
    parameter logic [DATA_W-1:0] VREF_CODE  = 8'hFF
) (
    input  logic              clk_10MHz,
    input  logic              reset_n,
    input  logic              sw_voltage,
    input  logic              sw_sawtooth,
    input  logic              sw_triangle,
    input  logic              ovr_clr,
    input  logic              spi_ready,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    output logic [1:0]        mode,
    output logic              sample_ovr
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          rst_sync;
    logic                rst_n;
    logic [2:0]          sw_raw;
    logic [2:0]          sw_meta;
    logic [2:0]          sw_sync;
    logic [2:0]          sw_deb;
    logic [DEB_W-1:0]    deb_cnt [0:2];
    logic [1:0]          pending_mode;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [DATA_W-1:0]   acc;
    logic                dir_down;

    // Reset asserts asynchronously everywhere but releases two clocks later, in step with clk_10MHz.
    always_ff @(posedge clk_10MHz or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign sw_raw = {sw_triangle, sw_sawtooth, sw_voltage};

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
            sw_deb  <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
            for (int i = 0; i < 3; i++) begin
                if (sw_sync[i] == sw_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    sw_deb[i]  <= sw_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pending_mode = 2'd0;
        if      (sw_deb[0]) pending_mode = 2'd1;
        else if (sw_deb[1]) pending_mode = 2'd2;
        else if (sw_deb[2]) pending_mode = 2'd3;
    end

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        case (state)
            IDLE:  if (tick) state_nxt = CALC;
            CALC:  state_nxt = ISSUE;
            ISSUE: if (spi_ready) begin
                       spi_start = 1'b1;
                       state_nxt = IDLE;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    // A dropped tick leaves mode and accumulator untouched, so a pending code is never disturbed.
    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= 2'd0;
            acc      <= '0;
            dir_down <= 1'b0;
            spi_data <= '0;
        end else if (state == IDLE) begin
            if (tick && (pending_mode != mode)) begin
                mode     <= pending_mode;
                acc      <= '0;
                dir_down <= 1'b0;
            end
        end else if (state == CALC) begin
            case (mode)
                2'd0: spi_data <= '0;
                2'd1: spi_data <= VREF_CODE;
                2'd2: begin
                    spi_data <= acc;
                    acc      <= acc + 1'b1;
                end
                default: begin
                    spi_data <= acc;
                    if (!dir_down) begin
                        if (acc == '1) begin
                            dir_down <= 1'b1;
                            acc      <= acc - 1'b1;
                        end else begin
                            acc <= acc + 1'b1;
                        end
                    end else begin
                        if (acc == '0) begin
                            dir_down <= 1'b0;
                            acc      <= acc + 1'b1;
                        end else begin
                            acc <= acc - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        if (!rst_n)                      sample_ovr <= 1'b0;
        else if (tick && state != IDLE)  sample_ovr <= 1'b1;
        else if (ovr_clr)                sample_ovr <= 1'b0;
    end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb/tb_dac_sample_sequencer.sv - scoreboard bench for dac_sample_sequencer
`timescale 1ns/1ps
module tb_dac_sample_sequencer;

    logic       clk_10MHz = 1'b0;
    logic       reset_n;
    logic       sw_voltage;
    logic       sw_sawtooth;
    logic       sw_triangle;
    logic       ovr_clr;
    logic       spi_ready;
    logic       spi_start;
    logic [7:0] spi_data;
    logic [1:0] mode;
    logic       sample_ovr;

    int         errors = 0;
    int         checks = 0;
    int         tri_k  = 0;
    logic [7:0] exp_q[$];

    always #50 clk_10MHz = ~clk_10MHz;

    dac_sample_sequencer #(
        .SAMPLE_DIV(8),
        .DATA_W    (8),
        .DEB_CYCLES(16),
        .VREF_CODE (8'hFF)
    ) dut (
        .clk_10MHz  (clk_10MHz),
        .reset_n    (reset_n),
        .sw_voltage (sw_voltage),
        .sw_sawtooth(sw_sawtooth),
        .sw_triangle(sw_triangle),
        .ovr_clr    (ovr_clr),
        .spi_ready  (spi_ready),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .mode       (mode),
        .sample_ovr (sample_ovr)
    );

    function automatic logic [7:0] tri_val(input int k);
        int p;
        p = k % 510;
        return (p <= 255) ? 8'(p) : 8'(510 - p);
    endfunction

    task automatic wait_start(input int budget, output bit got, output logic [7:0] data, output int waited);
        got = 1'b0;
        waited = 0;
        data = '0;
        while (!got && waited < budget) begin
            @(negedge clk_10MHz);
            waited++;
            if (spi_start) begin
                got = 1'b1;
                data = spi_data;
            end
        end
    endtask

    task automatic wait_mode(input logic [1:0] m, input int budget, output bit got);
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < budget) begin
            @(negedge clk_10MHz);
            n++;
            if (mode === m) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        bit got;
        logic [7:0] d, e;
        int w;
        reset_n = 1'b0; sw_voltage = 1'b0; sw_sawtooth = 1'b0; sw_triangle = 1'b0;
        ovr_clr = 1'b0; spi_ready = 1'b1;
        repeat (3) @(negedge clk_10MHz);
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", spi_start); end
        checks++; if (spi_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %0h expected 0", spi_data); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_mode: got %0d expected 0", mode); end
        checks++; if (sample_ovr !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b expected 0", sample_ovr); end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h00);
            wait_start(40, got, d, w);
            e = exp_q.pop_front();
            checks++; if (!got || d !== e) begin errors++; $display("FAIL off_data[%0d]: got %0h (start=%b) expected %0h", i, d, got, e); end
        end
    endtask

    task automatic test_sawtooth;
        bit got;
        logic [7:0] d, e;
        int w;
        sw_sawtooth = 1'b1;
        wait_mode(2'd2, 200, got);
        checks++; if (!got) begin errors++; $display("FAIL saw_mode: got %0d expected 2", mode); end
        for (int i = 0; i < 257; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 257; i++) begin
            wait_start(40, got, d, w);
            e = exp_q.pop_front();
            checks++; if (!got || d !== e) begin errors++; $display("FAIL saw_data[%0d]: got %0h (start=%b) expected %0h", i, d, got, e); end
            checks++; if (w !== ((i == 0) ? 1 : 8)) begin errors++; $display("FAIL saw_spacing[%0d]: got %0d cycles expected %0d", i, w, (i == 0) ? 1 : 8); end
        end
    endtask

    task automatic test_triangle;
        bit got;
        logic [7:0] d, e;
        int w, n_max, n_zero;
        n_max = 0;
        n_zero = 0;
        sw_sawtooth = 1'b0;
        sw_triangle = 1'b1;
        wait_mode(2'd3, 200, got);
        checks++; if (!got) begin errors++; $display("FAIL tri_mode: got %0d expected 3", mode); end
        for (int k = 0; k < 512; k++) exp_q.push_back(tri_val(k));
        for (int k = 0; k < 512; k++) begin
            wait_start(40, got, d, w);
            e = exp_q.pop_front();
            checks++; if (!got || d !== e) begin errors++; $display("FAIL tri_data[%0d]: got %0h (start=%b) expected %0h", k, d, got, e); end
            if (k < 510 && d == 8'hFF) n_max++;
            if (k < 510 && d == 8'h00) n_zero++;
        end
        checks++; if (n_max !== 1) begin errors++; $display("FAIL tri_max_once: got %0d expected 1", n_max); end
        checks++; if (n_zero !== 1) begin errors++; $display("FAIL tri_zero_once: got %0d expected 1", n_zero); end
    endtask

    task automatic test_priority;
        bit got;
        logic [7:0] d, e;
        int w;
        sw_voltage = 1'b1;
        wait_mode(2'd1, 200, got);
        checks++; if (!got) begin errors++; $display("FAIL vref_mode: got %0d expected 1", mode); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hFF);
            wait_start(40, got, d, w);
            e = exp_q.pop_front();
            checks++; if (!got || d !== e) begin errors++; $display("FAIL vref_data[%0d]: got %0h (start=%b) expected %0h", i, d, got, e); end
        end
        sw_voltage = 1'b0;
        wait_mode(2'd3, 200, got);
        checks++; if (!got) begin errors++; $display("FAIL back_to_tri_mode: got %0d expected 3", mode); end
        tri_k = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(tri_val(tri_k));
            tri_k++;
            wait_start(40, got, d, w);
            e = exp_q.pop_front();
            checks++; if (!got || d !== e) begin errors++; $display("FAIL back_to_tri_data[%0d]: got %0h (start=%b) expected %0h", i, d, got, e); end
        end
    endtask

    task automatic test_glitch;
        bit got;
        logic [7:0] d, e;
        int w;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(tri_val(tri_k));
            tri_k++;
            wait_start(40, got, d, w);
            e = exp_q.pop_front();
            checks++; if (!got || d !== e) begin errors++; $display("FAIL glitch_data[%0d]: got %0h (start=%b) expected %0h", i, d, got, e); end
            checks++; if (mode !== 2'd3) begin errors++; $display("FAIL glitch_mode[%0d]: got %0d expected 3", i, mode); end
            if (i == 1) begin
                @(posedge clk_10MHz); #1 sw_sawtooth = 1'b1;
            end
            if (i == 2) begin
                repeat (3) @(posedge clk_10MHz);
                #1 sw_sawtooth = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure;
        bit got, any_start, stable;
        logic [7:0] d, e, held;
        int w;
        exp_q.push_back(tri_val(tri_k));
        tri_k++;
        wait_start(40, got, d, w);
        e = exp_q.pop_front();
        checks++; if (!got || d !== e) begin errors++; $display("FAIL bp_pre_data: got %0h (start=%b) expected %0h", d, got, e); end
        @(posedge clk_10MHz); #1 spi_ready = 1'b0;
        held = tri_val(tri_k);
        tri_k++;
        repeat (8) @(negedge clk_10MHz);
        checks++; if (spi_start !== 1'b0 || spi_data !== held) begin errors++; $display("FAIL bp_issue_held: got start=%b data=%0h expected start=0 data=%0h", spi_start, spi_data, held); end
        any_start = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_10MHz);
            if (spi_start) any_start = 1'b1;
            if (spi_data !== held) stable = 1'b0;
        end
        checks++; if (any_start !== 1'b0) begin errors++; $display("FAIL bp_no_start: got start seen=%b expected 0", any_start); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_data_stable: got stable=%b expected 1", stable); end
        checks++; if (sample_ovr !== 1'b1) begin errors++; $display("FAIL bp_ovr_set: got %b expected 1", sample_ovr); end
        spi_ready = 1'b1;
        #1;
        checks++; if (spi_start !== 1'b1 || spi_data !== held) begin errors++; $display("FAIL bp_release: got start=%b data=%0h expected start=1 data=%0h", spi_start, spi_data, held); end
        exp_q.push_back(tri_val(tri_k));
        tri_k++;
        wait_start(40, got, d, w);
        e = exp_q.pop_front();
        checks++; if (!got || d !== e) begin errors++; $display("FAIL bp_single_advance: got %0h (start=%b) expected %0h", d, got, e); end
        checks++; if (sample_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", sample_ovr); end
        ovr_clr = 1'b1;
        @(negedge clk_10MHz);
        ovr_clr = 1'b0;
        checks++; if (sample_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b expected 0", sample_ovr); end
    endtask

    task automatic test_reset_in_issue;
        bit got;
        logic [7:0] d, e, held;
        int w;
        exp_q.push_back(tri_val(tri_k));
        tri_k++;
        wait_start(40, got, d, w);
        e = exp_q.pop_front();
        checks++; if (!got || d !== e) begin errors++; $display("FAIL rii_pre_data: got %0h (start=%b) expected %0h", d, got, e); end
        @(posedge clk_10MHz); #1 spi_ready = 1'b0;
        held = tri_val(tri_k);
        repeat (8) @(negedge clk_10MHz);
        checks++; if (spi_data !== held) begin errors++; $display("FAIL rii_held: got %0h expected %0h", spi_data, held); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rii_start: got %b expected 0", spi_start); end
        checks++; if (spi_data !== 8'h00) begin errors++; $display("FAIL rii_data: got %0h expected 0", spi_data); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rii_mode: got %0d expected 0", mode); end
        sw_triangle = 1'b0;
        spi_ready = 1'b1;
        repeat (3) @(negedge clk_10MHz);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h00);
            wait_start(40, got, d, w);
            e = exp_q.pop_front();
            checks++; if (!got || d !== e) begin errors++; $display("FAIL rii_after_data[%0d]: got %0h (start=%b) expected %0h", i, d, got, e); end
            checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rii_after_mode[%0d]: got %0d expected 0", i, mode); end
        end
    endtask

    initial begin
        test_reset;
        test_sawtooth;
        test_triangle;
        test_priority;
        test_glitch;
        test_backpressure;
        test_reset_in_issue;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
